// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: state, opcode and datapath-select encodings for the multicycle controller
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECUTER = 4'd6, ALUWB = 4'd7, EXECUTEI = 4'd8, JAL = 4'd9, BEQ = 4'd10
  } statetype;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10;
  localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
  localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;
endpackage

// File: rtl/main_fsm.sv
// main_fsm: Moore state machine sequencing fetch, decode and execute for the multicycle datapath
module main_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic [3:0] state,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [1:0] aluop,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       pcupdate,
  output logic       branch
);
  statetype cur, nxt;
  logic irw, rgw, mmw, pcu, br;
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= FETCH;
    else cur <= nxt;
  always_comb begin
    nxt = FETCH;
    alusrca = SRCA_PC;
    alusrcb = SRCB_RD2;
    resultsrc = RES_ALUOUT;
    aluop = ALUOP_ADD;
    adrsrc = 1'b0;
    irw = 1'b0;
    rgw = 1'b0;
    mmw = 1'b0;
    pcu = 1'b0;
    br = 1'b0;
    case (cur)
      FETCH: begin
        alusrcb = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        irw = 1'b1;
        pcu = 1'b1;
        nxt = DECODE;
      end
      DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
              op == OP_R   ? EXECUTER :
              op == OP_I   ? EXECUTEI :
              op == OP_JAL ? JAL :
              op == OP_BEQ ? BEQ : FETCH;
      end
      MEMADR: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        nxt = op == OP_LW ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrsrc = 1'b1;
        nxt = MEMWB;
      end
      MEMWB: begin
        resultsrc = RES_DATA;
        rgw = 1'b1;
      end
      MEMWRITE: begin
        adrsrc = 1'b1;
        mmw = 1'b1;
      end
      EXECUTER: begin
        alusrca = SRCA_RD1;
        aluop = ALUOP_FUNCT;
        nxt = ALUWB;
      end
      ALUWB: rgw = 1'b1;
      EXECUTEI: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        aluop = ALUOP_FUNCT;
        nxt = ALUWB;
      end
      JAL: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_FOUR;
        pcu = 1'b1;
        nxt = ALUWB;
      end
      BEQ: begin
        alusrca = SRCA_RD1;
        aluop = ALUOP_SUB;
        br = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end
  // Reset is asynchronous, so enables are masked combinationally to keep them quiet the instant it rises
  assign irwrite = irw & ~reset;
  assign regwrite = rgw & ~reset;
  assign memwrite = mmw & ~reset;
  assign pcupdate = pcu & ~reset;
  assign branch = br & ~reset;
  assign state = cur;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control unit for the multicycle RV32I subset processor
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [1:0] aluop,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic [3:0] state
);
  logic pcupdate, branch;
  main_fsm u_fsm (
    .clk(clk), .reset(reset), .op(op), .state(state), .alusrca(alusrca), .alusrcb(alusrcb),
    .resultsrc(resultsrc), .aluop(aluop), .adrsrc(adrsrc), .irwrite(irwrite),
    .regwrite(regwrite), .memwrite(memwrite), .pcupdate(pcupdate), .branch(branch)
  );
  always_comb
    immsrc = op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  assign pcwrite = pcupdate | (branch & zero);
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction stream checked cycle-by-cycle through a scoreboard
module tb_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, adrsrc, irwrite, pcwrite, regwrite, memwrite;
  logic [6:0] op = 7'b0000011;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc, aluop;
  logic [3:0] state;
  int tests = 0, fails = 0;
  logic [19:0] sb[$];
  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .immsrc(immsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .resultsrc(resultsrc), .adrsrc(adrsrc), .aluop(aluop), .irwrite(irwrite),
    .pcwrite(pcwrite), .regwrite(regwrite), .memwrite(memwrite), .state(state)
  );
  always #5 clk = ~clk;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
  // Per-state datapath controls, transcribed from the state descriptions (index = state number)
  bit [1:0] t_srca[11] = '{0, 1, 2, 0, 0, 0, 2, 0, 2, 1, 2};
  bit [1:0] t_srcb[11] = '{2, 1, 1, 0, 0, 0, 0, 0, 1, 2, 0};
  bit [1:0] t_res[11] = '{2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  bit [1:0] t_aluop[11] = '{0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1};
  bit t_adr[11] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
  function automatic void path(input logic [6:0] o, output int s[$]);
    s = '{0, 1};
    if (o == LW) s = '{0, 1, 2, 3, 4};
    else if (o == SW) s = '{0, 1, 2, 5};
    else if (o == RT) s = '{0, 1, 6, 7};
    else if (o == IT) s = '{0, 1, 8, 7};
    else if (o == JL) s = '{0, 1, 9, 7};
    else if (o == BQ) s = '{0, 1, 10};
  endfunction
  function automatic logic [19:0] expect_of(input int s, input logic [6:0] o, input logic z);
    logic [1:0] imm;
    logic pcw;
    imm = o == SW ? 2'd1 : o == BQ ? 2'd2 : o == JL ? 2'd3 : 2'd0;
    pcw = s == 0 || s == 9 || (s == 10 && z);
    return {4'(s), imm, t_srca[s], t_srcb[s], t_res[s], t_aluop[s], t_adr[s], s == 0, pcw,
            s == 4 || s == 7, s == 5};
  endfunction
  task automatic issue(input logic [6:0] o, input logic z, input int keep);
    int s[$];
    path(o, s);
    if (keep > 0 && keep < s.size()) s = s[0:keep-1];
    foreach (s[i]) sb.push_back(expect_of(s[i], o, z));
    op = o;
    zero = z;
  endtask
  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask
  always @(negedge clk) begin
    logic [19:0] got, want;
    if (!reset && sb.size() > 0) begin
      want = sb.pop_front();
      got = {state, immsrc, alusrca, alusrcb, resultsrc, aluop, adrsrc, irwrite, pcwrite,
             regwrite, memwrite};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL cycle t=%0t op=%b got %05h want %05h", $time, op, got, want);
      end
    end
  end
  initial begin
    logic [6:0] legal[6] = '{LW, SW, RT, IT, JL, BQ};
    logic [6:0] o;
    int s[$];
    #2;
    check("rst_state", state, 4'd0);
    check("rst_irwrite", {3'b0, irwrite}, 4'd0);
    check("rst_pcwrite", {3'b0, pcwrite}, 4'd0);
    check("rst_alusrcb", {2'b0, alusrcb}, 4'd2);
    check("rst_resultsrc", {2'b0, resultsrc}, 4'd2);
    @(posedge clk); #1;
    // Directed classes first, then a random stream
    foreach (legal[i]) for (int z = 0; z < 2; z++) begin
      issue(legal[i], z[0], 0);
      reset = 1'b0;
      path(legal[i], s);
      repeat (s.size()) @(posedge clk);
      #1;
    end
    issue(7'b1111111, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 300; n++) begin
      o = legal[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) begin
        o = 7'($urandom);
        foreach (legal[i]) if (o == legal[i]) o = 7'b1111111;
      end
      issue(o, 1'($urandom), 0);
      path(o, s);
      repeat (s.size()) @(posedge clk);
      #1;
    end
    issue(SW, 1'b0, 3);
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_memwrite", {3'b0, memwrite}, 4'd1);
    reset = 1'b1;
    #1;
    check("async_state", state, 4'd0);
    check("async_memwrite", {3'b0, memwrite}, 4'd0);
    check("async_irwrite", {3'b0, irwrite}, 4'd0);
    check("async_pcwrite", {3'b0, pcwrite}, 4'd0);
    check("async_regwrite", {3'b0, regwrite}, 4'd0);
    @(posedge clk); #1;
    issue(LW, 1'b0, 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 4'(sb.size()), 4'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
